register_file_scoreboard: RTL and testbench
===========================================

REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when set.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled when set.
REQ-005 The block SHALL have port Clk, input, 1 bit: single clock, all state on rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port Register_Write, input, 1 bit: writeback strobe.
REQ-008 The block SHALL have port Write_Reg, input, ADDR_W bits: writeback address.
REQ-009 The block SHALL have port Register_Write_Data, input, DATA_W bits: writeback data.
REQ-010 The block SHALL have ports Read_Reg_1 and Read_Reg_2, input, ADDR_W bits each: read addresses.
REQ-011 The block SHALL have ports Read_Data_1 and Read_Data_2, output, DATA_W bits each: read data.
REQ-012 The block SHALL have ports Busy_1 and Busy_2, output, 1 bit each: the read register awaits a pending writeback.
REQ-013 The block SHALL have port Issue_Valid, input, 1 bit: request to reserve a destination register.
REQ-014 The block SHALL have port Issue_Reg, input, ADDR_W bits: destination register to reserve.
REQ-015 The block SHALL have port Issue_Ready, output, 1 bit: reservation is accepted this cycle.
REQ-016 The block SHALL have port Pending_Count, output, ADDR_W+1 bits: number of reserved registers.
REQ-017 The block SHALL have port Write_Unexpected, output, 1 bit: one-cycle registered pulse flagging a writeback to a non-pending register.

Function
REQ-018 Reads SHALL be combinational; Read_Data_n = array[Read_Reg_n], or 0 when ZERO_REG and Read_Reg_n==0.
REQ-019 On a rising edge with Register_Write=1, the block SHALL write Register_Write_Data to Write_Reg, except that writes to register 0 are discarded when ZERO_REG=1.
REQ-020 With BYPASS=1, Register_Write=1 and Write_Reg==Read_Reg_n (non-zero), the block SHALL drive Read_Data_n = Register_Write_Data in the same cycle.
REQ-021 The block SHALL keep one pending bit per register; register 0 is never pending when ZERO_REG=1.
REQ-022 Issue_Ready SHALL be 1 when pending[Issue_Reg]=0, OR when Register_Write=1 and Write_Reg==Issue_Reg in the same cycle, OR when Issue_Reg==0 and ZERO_REG=1.
REQ-023 Issue_Valid & Issue_Ready SHALL set pending[Issue_Reg] at the edge; an issue to register 0 with ZERO_REG=1 SHALL be accepted without setting any bit.
REQ-024 Register_Write SHALL clear pending[Write_Reg] at the edge.
REQ-025 When an issue and a writeback target the same register in one cycle, set SHALL win; the bit remains 1 and Pending_Count is unchanged.
REQ-026 Busy_n SHALL be pending[Read_Reg_n] AND NOT (BYPASS=1 and a same-cycle writeback to Read_Reg_n).
REQ-027 Pending_Count SHALL be registered and track the population count of pending bits, with +1 on a net set, -1 on a net clear, and 0 change when both or neither occur; it can never exceed 2**ADDR_W.
REQ-028 A writeback to a register whose pending bit is 0 SHALL still update data; Write_Unexpected SHALL pulse high the next cycle, and the count SHALL be unchanged; this does not apply to register 0 with ZERO_REG=1.
REQ-029 Issue_Valid=0 SHALL leave Issue_Ready computed but SHALL cause no state change.

Reset
REQ-030 Reset=1 SHALL asynchronously clear all registers to 0, all pending bits to 0, Pending_Count to 0 and Write_Unexpected to 0.
REQ-031 A write or issue coinciding with Reset SHALL be discarded.
REQ-032 After Reset, Issue_Ready SHALL be 1 for every address, and Busy_1 and Busy_2 SHALL be 0.

Structure
REQ-033 A shared package SHALL hold the DATA_W/ADDR_W defaults and a depth constant derived from ADDR_W.
REQ-034 The scoreboard SHALL be a sub-module rf_scoreboard, which holds the pending bits, Issue_Ready, Busy, Pending_Count and Write_Unexpected; the data array stays in the top level.

Verification
REQ-035 Reset, then write 0xDEADBEEF to r5, then read r5 next cycle -> Read_Data_1=0xDEADBEEF; write 0x1234 to r0 -> reads of r0 return 0.
REQ-036 Write r7=0xA5A5A5A5 with Read_Reg_2=7 in the same cycle -> Read_Data_2=0xA5A5A5A5 combinationally; with BYPASS=0 -> the old value is returned.
REQ-037 Issue r3, then the next cycle Read_Reg_1=3 -> Busy_1=1, Pending_Count=1, and a second issue of r3 sees Issue_Ready=0; writeback r3 -> Busy_1=0, Pending_Count=0.
REQ-038 With r4 pending, issue r4 and write back r4 in the same cycle -> pending[r4] stays 1 and Pending_Count stays 1.
REQ-039 Write back r9 with r9 not pending -> data is updated, Write_Unexpected=1 for exactly one cycle, and Pending_Count is unchanged.
REQ-040 Issue r1, r2 and r6, then assert Reset mid-cycle -> all outputs are 0 immediately, Pending_Count=0, and Issue_Ready=1.

Source files
------------

// File: rtl/register_file_scoreboard_pkg.sv
// Shared sizing constants for the register file and its scoreboard.
package register_file_scoreboard_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  // Number of registers addressable with an address of the given width.
  function automatic int depthOf(input int addrW);
    return 1 << addrW;
  endfunction

endpackage

// File: rtl/register_file_scoreboard_rf_scoreboard.sv
// Pending-writeback scoreboard. It tracks one reservation bit per register,
// arbitrates issue requests, and flags writebacks that nobody was waiting for.
module rf_scoreboard
  import register_file_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_regWrite,
  input  logic [ADDR_W-1:0] i_writeReg,
  input  logic [ADDR_W-1:0] i_readReg1,
  input  logic [ADDR_W-1:0] i_readReg2,
  input  logic              i_issueValid,
  input  logic [ADDR_W-1:0] i_issueReg,
  output logic              o_issueReady,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic [ADDR_W:0]   o_pendingCount,
  output logic              o_writeUnexpected
);

  localparam int DEPTH = depthOf(ADDR_W);
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

  logic [DEPTH-1:0] r_pending;
  logic [ADDR_W:0]  r_pendingCount;
  logic             r_writeUnexpected;

  logic w_writeHit;
  logic w_issueZero;
  logic w_issueFire;
  logic w_countInc;
  logic w_countDec;
  logic w_unexpected;

  // Decode issue acceptance, count movement and writeback sanity. The count
  // follows real bit transitions, so a set and clear landing on one already
  // pending register leaves it untouched.
  always_comb begin
    w_writeHit   = i_regWrite && !(ZERO_REG && (i_writeReg == '0));
    w_issueZero  = ZERO_REG && (i_issueReg == '0);
    o_issueReady = !r_pending[i_issueReg]
                || (i_regWrite && (i_writeReg == i_issueReg))
                || w_issueZero;
    w_issueFire  = i_issueValid && o_issueReady && !w_issueZero;
    w_countInc   = w_issueFire && !r_pending[i_issueReg];
    w_countDec   = w_writeHit && r_pending[i_writeReg]
                && !(w_issueFire && (i_issueReg == i_writeReg));
    w_unexpected = w_writeHit && !r_pending[i_writeReg];
    o_busy1      = r_pending[i_readReg1]
                && !(BYPASS && i_regWrite && (i_writeReg == i_readReg1));
    o_busy2      = r_pending[i_readReg2]
                && !(BYPASS && i_regWrite && (i_writeReg == i_readReg2));
  end

  // Update pending bits (set wins over clear), the count and the pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending         <= '0;
      r_pendingCount    <= '0;
      r_writeUnexpected <= 1'b0;
    end else begin
      if (w_writeHit) begin
        r_pending[i_writeReg] <= 1'b0;
      end
      if (w_issueFire) begin
        r_pending[i_issueReg] <= 1'b1;
      end
      case ({w_countInc, w_countDec})
        2'b10:   r_pendingCount <= r_pendingCount + COUNT_ONE;
        2'b01:   r_pendingCount <= r_pendingCount - COUNT_ONE;
        default: r_pendingCount <= r_pendingCount;
      endcase
      r_writeUnexpected <= w_unexpected;
    end
  end

  assign o_pendingCount    = r_pendingCount;
  assign o_writeUnexpected = r_writeUnexpected;

endmodule

// File: rtl/register_file_scoreboard.sv
// Register file with two combinational read ports, one writeback port,
// optional write-to-read forwarding and a pending-writeback scoreboard.
module register_file_scoreboard
  import register_file_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Register_Write,
  input  logic [ADDR_W-1:0] Write_Reg,
  input  logic [DATA_W-1:0] Register_Write_Data,
  input  logic [ADDR_W-1:0] Read_Reg_1,
  input  logic [ADDR_W-1:0] Read_Reg_2,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2,
  output logic              Busy_1,
  output logic              Busy_2,
  input  logic              Issue_Valid,
  input  logic [ADDR_W-1:0] Issue_Reg,
  output logic              Issue_Ready,
  output logic [ADDR_W:0]   Pending_Count,
  output logic              Write_Unexpected
);

  localparam int DEPTH = depthOf(ADDR_W);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_writeEn;

  assign w_writeEn = Register_Write && !(ZERO_REG && (Write_Reg == '0));

  // Store writeback data; register 0 ignores writes when hardwired.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeEn) begin
      r_regs[Write_Reg] <= Register_Write_Data;
    end
  end

  // Read port 1: zero register, then forwarded writeback, then the array.
  always_comb begin
    Read_Data_1 = r_regs[Read_Reg_1];
    if (ZERO_REG && (Read_Reg_1 == '0)) begin
      Read_Data_1 = '0;
    end else if (BYPASS && Register_Write && (Write_Reg == Read_Reg_1)) begin
      Read_Data_1 = Register_Write_Data;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    Read_Data_2 = r_regs[Read_Reg_2];
    if (ZERO_REG && (Read_Reg_2 == '0)) begin
      Read_Data_2 = '0;
    end else if (BYPASS && Register_Write && (Write_Reg == Read_Reg_2)) begin
      Read_Data_2 = Register_Write_Data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .i_clk             (Clk),
    .i_rst             (Reset),
    .i_regWrite        (Register_Write),
    .i_writeReg        (Write_Reg),
    .i_readReg1        (Read_Reg_1),
    .i_readReg2        (Read_Reg_2),
    .i_issueValid      (Issue_Valid),
    .i_issueReg        (Issue_Reg),
    .o_issueReady      (Issue_Ready),
    .o_busy1           (Busy_1),
    .o_busy2           (Busy_2),
    .o_pendingCount    (Pending_Count),
    .o_writeUnexpected (Write_Unexpected)
  );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: a vector table for the main
// behaviour plus hand-written sequences for forwarding and reset corners.
module tb_register_file_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        regWrite = 1'b0;
  logic [4:0]  writeReg = '0;
  logic [31:0] writeData = '0;
  logic [4:0]  readReg1 = '0;
  logic [4:0]  readReg2 = '0;
  logic        issueValid = 1'b0;
  logic [4:0]  issueReg = '0;

  logic [31:0] readData1, readData2;
  logic        busy1, busy2, issueReady, writeUnexpected;
  logic [5:0]  pendingCount;

  logic [31:0] nbReadData1, nbReadData2;
  logic        nbBusy1, nbBusy2, nbIssueReady, nbWriteUnexpected;
  logic [5:0]  nbPendingCount;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  wReg;
    logic [31:0] wData;
    logic [4:0]  rReg1;
    logic [4:0]  rReg2;
    logic        iValid;
    logic [4:0]  iReg;
    logic [31:0] expRd1;
    logic [31:0] expRd2;
    logic        expBusy1;
    logic        expBusy2;
    logic        expReady;
    logic [5:0]  expCount;
    logic        expUnexp;
  } vec_t;

  vec_t vecs [20];

  register_file_scoreboard dut (
    .Clk(clk), .Reset(reset), .Register_Write(regWrite), .Write_Reg(writeReg),
    .Register_Write_Data(writeData), .Read_Reg_1(readReg1), .Read_Reg_2(readReg2),
    .Read_Data_1(readData1), .Read_Data_2(readData2), .Busy_1(busy1), .Busy_2(busy2),
    .Issue_Valid(issueValid), .Issue_Reg(issueReg), .Issue_Ready(issueReady),
    .Pending_Count(pendingCount), .Write_Unexpected(writeUnexpected)
  );

  register_file_scoreboard #(.BYPASS(1'b0)) dutNb (
    .Clk(clk), .Reset(reset), .Register_Write(regWrite), .Write_Reg(writeReg),
    .Register_Write_Data(writeData), .Read_Reg_1(readReg1), .Read_Reg_2(readReg2),
    .Read_Data_1(nbReadData1), .Read_Data_2(nbReadData2), .Busy_1(nbBusy1), .Busy_2(nbBusy2),
    .Issue_Valid(issueValid), .Issue_Reg(issueReg), .Issue_Ready(nbIssueReady),
    .Pending_Count(nbPendingCount), .Write_Unexpected(nbWriteUnexpected)
  );

  always #5 clk = ~clk;

  // Drive one set of inputs from a vector record.
  task automatic applyStimulus(input vec_t v);
    regWrite   = v.wr;
    writeReg   = v.wReg;
    writeData  = v.wData;
    readReg1   = v.rReg1;
    readReg2   = v.rReg2;
    issueValid = v.iValid;
    issueReg   = v.iReg;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0; issueValid = 1'b0; issueReg = '0;
  endtask

  initial begin
    //          wr wReg  wData          r1  r2  iv iReg  rd1            rd2            b1 b2 rdy cnt unx
    vecs[0]  = '{1, 5'd5,  32'hDEADBEEF, 5,  0,  0, 0,   32'hDEADBEEF, 32'h0,        0, 0, 1, 0, 0};
    vecs[1]  = '{0, 5'd0,  32'h0,        5,  0,  0, 0,   32'hDEADBEEF, 32'h0,        0, 0, 1, 0, 1};
    vecs[2]  = '{1, 5'd0,  32'h1234,     0,  5,  0, 0,   32'h0,        32'hDEADBEEF, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 5'd0,  32'h0,        0,  0,  0, 0,   32'h0,        32'h0,        0, 0, 1, 0, 0};
    vecs[4]  = '{0, 5'd0,  32'h0,        3,  0,  1, 3,   32'h0,        32'h0,        0, 0, 1, 0, 0};
    vecs[5]  = '{0, 5'd0,  32'h0,        3,  0,  1, 3,   32'h0,        32'h0,        1, 0, 0, 1, 0};
    vecs[6]  = '{1, 5'd3,  32'h33,       3,  3,  0, 3,   32'h33,       32'h33,       0, 0, 1, 1, 0};
    vecs[7]  = '{0, 5'd0,  32'h0,        3,  0,  0, 3,   32'h33,       32'h0,        0, 0, 1, 0, 0};
    vecs[8]  = '{0, 5'd0,  32'h0,        4,  0,  1, 4,   32'h0,        32'h0,        0, 0, 1, 0, 0};
    vecs[9]  = '{1, 5'd4,  32'h44,       4,  0,  1, 4,   32'h44,       32'h0,        0, 0, 1, 1, 0};
    vecs[10] = '{0, 5'd0,  32'h0,        4,  0,  0, 4,   32'h44,       32'h0,        1, 0, 0, 1, 0};
    vecs[11] = '{1, 5'd4,  32'h4444,     4,  0,  0, 0,   32'h4444,     32'h0,        0, 0, 1, 1, 0};
    vecs[12] = '{0, 5'd0,  32'h0,        4,  0,  0, 0,   32'h4444,     32'h0,        0, 0, 1, 0, 0};
    vecs[13] = '{1, 5'd9,  32'h99,       0,  9,  0, 0,   32'h0,        32'h99,       0, 0, 1, 0, 0};
    vecs[14] = '{0, 5'd0,  32'h0,        0,  9,  0, 0,   32'h0,        32'h99,       0, 0, 1, 0, 1};
    vecs[15] = '{0, 5'd0,  32'h0,        0,  9,  0, 0,   32'h0,        32'h99,       0, 0, 1, 0, 0};
    vecs[16] = '{0, 5'd0,  32'h0,        0,  10, 1, 10,  32'h0,        32'h0,        0, 0, 1, 0, 0};
    vecs[17] = '{0, 5'd0,  32'h0,        0,  10, 0, 0,   32'h0,        32'h0,        0, 1, 1, 1, 0};
    vecs[18] = '{1, 5'd10, 32'hAA,       0,  10, 0, 0,   32'h0,        32'hAA,       0, 0, 1, 1, 0};
    vecs[19] = '{0, 5'd0,  32'h0,        0,  10, 0, 0,   32'h0,        32'hAA,       0, 0, 1, 0, 0};

    // Reset state: everything zero, every address may be reserved.
    #1;
    checkOutput("reset_count", 32'(pendingCount), 32'd0);
    checkOutput("reset_unexp", 32'(writeUnexpected), 32'd0);
    checkOutput("reset_busy1", 32'(busy1), 32'd0);
    checkOutput("reset_busy2", 32'(busy2), 32'd0);
    checkOutput("reset_rd1", readData1, 32'd0);
    for (int a = 0; a < 32; a++) begin
      issueReg = 5'(a);
      #0.1;
      checkOutput($sformatf("reset_ready_r%0d", a), 32'(issueReady), 32'd1);
    end
    idleInputs();
    @(negedge clk);
    reset = 1'b0;

    // Table-driven main behaviour.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_rd1", i), readData1, vecs[i].expRd1);
      checkOutput($sformatf("v%0d_rd2", i), readData2, vecs[i].expRd2);
      checkOutput($sformatf("v%0d_busy1", i), 32'(busy1), 32'(vecs[i].expBusy1));
      checkOutput($sformatf("v%0d_busy2", i), 32'(busy2), 32'(vecs[i].expBusy2));
      checkOutput($sformatf("v%0d_ready", i), 32'(issueReady), 32'(vecs[i].expReady));
      checkOutput($sformatf("v%0d_count", i), 32'(pendingCount), 32'(vecs[i].expCount));
      checkOutput($sformatf("v%0d_unexp", i), 32'(writeUnexpected), 32'(vecs[i].expUnexp));
    end

    // Forwarding on versus off: same-cycle write to r7 seen on read port 2.
    @(negedge clk);
    idleInputs();
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'hA5A5A5A5; readReg2 = 5'd7;
    #1;
    checkOutput("bypass_on_rd2", readData2, 32'hA5A5A5A5);
    checkOutput("bypass_off_rd2", nbReadData2, 32'h0);
    @(negedge clk);
    idleInputs();
    readReg2 = 5'd7;
    #1;
    checkOutput("bypass_off_rd2_later", nbReadData2, 32'hA5A5A5A5);

    // Busy masking only when forwarding is enabled.
    @(negedge clk);
    idleInputs();
    issueValid = 1'b1; issueReg = 5'd11;
    @(negedge clk);
    idleInputs();
    regWrite = 1'b1; writeReg = 5'd11; writeData = 32'hB; readReg1 = 5'd11;
    #1;
    checkOutput("bypass_on_busy1", 32'(busy1), 32'd0);
    checkOutput("bypass_off_busy1", 32'(nbBusy1), 32'd1);

    // Three reservations, then an asynchronous reset in mid-cycle.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      idleInputs();
      issueValid = 1'b1;
      issueReg = (r == 0) ? 5'd1 : (r == 1) ? 5'd2 : 5'd6;
    end
    @(negedge clk);
    idleInputs();
    readReg1 = 5'd1; readReg2 = 5'd5; issueReg = 5'd1;
    #1;
    checkOutput("pre_reset_count", 32'(pendingCount), 32'd3);
    checkOutput("pre_reset_busy1", 32'(busy1), 32'd1);
    checkOutput("pre_reset_ready", 32'(issueReady), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_count", 32'(pendingCount), 32'd0);
    checkOutput("async_reset_busy1", 32'(busy1), 32'd0);
    checkOutput("async_reset_ready", 32'(issueReady), 32'd1);
    checkOutput("async_reset_rd2", readData2, 32'd0);
    checkOutput("async_reset_unexp", 32'(writeUnexpected), 32'd0);

    // Write and issue held across an edge during reset are dropped.
    @(negedge clk);
    regWrite = 1'b1; writeReg = 5'd13; writeData = 32'hFF;
    issueValid = 1'b1; issueReg = 5'd12;
    @(negedge clk);
    idleInputs();
    reset = 1'b0;
    readReg1 = 5'd13; readReg2 = 5'd12;
    #1;
    checkOutput("reset_drop_rd1", readData1, 32'd0);
    checkOutput("reset_drop_busy2", 32'(busy2), 32'd0);
    checkOutput("reset_drop_count", 32'(pendingCount), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("post_reset_count", 32'(pendingCount), 32'd0);
    checkOutput("post_reset_unexp", 32'(writeUnexpected), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
